systolic_array_os_flat: RTL and testbench

Output-stationary M×N grid of FP32 multiply-accumulate PEs, one per C element, fed by flattened row/column buses. Each accepted step delivers one k-slice: column k of A (M values) and row k of B (N values). Every PE(i,j) accumulates A[i][k]·B[k][j]. After the step flagged k_last, the C = A·B tile is published on c_out_flat. The block is the compute core under the tile controller, which sequences K steps per tile.

---
 rtl/systolic_array_os_flat.sv | 216 +++++++++++++++++++++
 tb/tb_systolic_array_os_flat.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_os_flat.sv
// systolic_array_os_flat
//   Output-stationary M x N grid of FP32 multiply-accumulate PEs, one per
//   element of C. Each accepted step carries one k-slice: column k of A on
//   a_row_flat and row k of B on b_col_flat. PE(i,j) accumulates
//   A[i][k]*B[k][j]. When the step flagged k_last finishes, the tile is
//   copied to c_out_flat.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-low reset
//   step_valid      step request
//   a_row_flat      A[i][k] at [i*32 +: 32]
//   b_col_flat      B[k][j] at [j*32 +: 32]
//   k_first         step restarts the accumulators
//   k_last          step publishes C when it completes
//   step_ready      high in IDLE (combinational)
//   c_out_flat      published C(i,j) at [(i*N+j)*32 +: 32]
//   c_valid_flat    sticky per-PE publish flag, bit i*N+j
//   psum_out_flat   live accumulators, same layout as c_out_flat
//
// Handshake: a step transfers on a rising edge where step_valid and
// step_ready are both 1. The data and flags are captured on that edge only.
// While busy, step_ready is 0 and step_valid is ignored (nothing is queued).
//
// Arithmetic: binary32 multiply, then a separately rounded add, both
// round-to-nearest-even. Subnormal inputs and results flush to signed zero,
// overflow saturates to signed Inf, and invalid operations return 0x7FC00000.
module systolic_array_os_flat #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_valid,
  input  logic [M*32-1:0]   a_row_flat,
  input  logic [N*32-1:0]   b_col_flat,
  input  logic              k_first,
  input  logic              k_last,
  output logic              step_ready,
  output logic [M*N*32-1:0] c_out_flat,
  output logic [M*N-1:0]    c_valid_flat,
  output logic [M*N*32-1:0] psum_out_flat
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, ACC = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [M*32-1:0]     a_q;
  logic [N*32-1:0]     b_q;
  logic                kf_q, kl_q;
  logic [M*N*32-1:0]   prod_q, prod_d, acc_d;

  // Round a 24-bit significand (hidden bit at [23]) with guard/sticky, then
  // range-check the exponent: overflow -> Inf, underflow -> signed zero.
  function automatic logic [31:0] fp32_pack(input logic s, input int e_in,
                                            input logic [23:0] m,
                                            input logic g, input logic st);
    logic [24:0] mr;
    int          e;
    e  = e_in;
    mr = {1'b0, m} + ((g && (st || m[0])) ? 25'd1 : 25'd0);
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e >= 255)    return {s, 8'hFF, 23'h0};
    else if (e <= 0) return {s, 31'h0};
    else             return {s, e[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fp32_mul(input logic [31:0] a,
                                           input logic [31:0] b);
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] pr;
    int          e;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_zero = (a[30:23] == 8'h00);  // zero or flushed subnormal
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf)   return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    pr = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (pr[47]) return fp32_pack(s, e + 1, pr[47:24], pr[23], |pr[22:0]);
    else        return fp32_pack(s, e,     pr[46:23], pr[22], |pr[21:0]);
  endfunction

  function automatic logic [31:0] fp32_add(input logic [31:0] a,
                                           input logic [31:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, st;
    logic [31:0] x, y;
    logic [26:0] mx, my, ys;
    logic [27:0] sm;
    int          d, e;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan) return QNAN;
    if (a_inf && b_inf) return (a[31] != b[31]) ? QNAN : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return 32'h0;
    if (a_zero) return b;
    if (b_zero) return a;
    // x is the operand of larger magnitude; y is aligned down to it.
    if (b[30:0] > a[30:0]) begin x = b; y = a; end
    else                   begin x = a; y = b; end
    // 27-bit significands: hidden bit, 23 fraction bits, guard/round/sticky.
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = int'(x[30:23]) - int'(y[30:23]);
    if (d >= 27) begin
      ys = 27'h0;
      st = 1'b1;
    end else begin
      ys = my >> d;
      st = |(my & ((27'd1 << d) - 27'd1));
    end
    ys[0] = ys[0] | st;
    if (x[31] == y[31]) sm = {1'b0, mx} + {1'b0, ys};
    else                sm = {1'b0, mx} - {1'b0, ys};
    if (sm == 28'h0) return 32'h0;  // exact cancellation is +0
    e = int'(x[30:23]);
    if (sm[27]) begin
      sm = {1'b0, sm[27:1]} | {27'h0, sm[0]};
      e  = e + 1;
    end else begin
      // Large left shifts only follow near-cancellation (d <= 1), where no
      // sticky information was lost during alignment.
      for (int k = 0; k < 27; k++) begin
        if (!sm[26]) begin
          sm = sm << 1;
          e  = e - 1;
        end
      end
    end
    return fp32_pack(x[31], e, sm[26:3], sm[2], |sm[1:0]);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_valid) state_d = MUL;
      MUL:     state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    step_ready = (state_q == IDLE);
  end

  // Per-PE products and accumulator updates, all PEs in lockstep.
  always_comb begin
    prod_d = '0;
    acc_d  = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        prod_d[(i*N+j)*32 +: 32] = fp32_mul(a_q[i*32 +: 32], b_q[j*32 +: 32]);
        acc_d[(i*N+j)*32 +: 32]  = kf_q ? prod_q[(i*N+j)*32 +: 32]
                                        : fp32_add(psum_out_flat[(i*N+j)*32 +: 32],
                                                   prod_q[(i*N+j)*32 +: 32]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q           <= '0;
      b_q           <= '0;
      kf_q          <= 1'b0;
      kl_q          <= 1'b0;
      prod_q        <= '0;
      psum_out_flat <= '0;
      c_out_flat    <= '0;
      c_valid_flat  <= '0;
    end else begin
      case (state_q)
        IDLE: if (step_valid) begin
          a_q  <= a_row_flat;
          b_q  <= b_col_flat;
          kf_q <= k_first;
          kl_q <= k_last;
          if (k_first) c_valid_flat <= '0;
        end
        MUL: prod_q <= prod_d;
        ACC: begin
          psum_out_flat <= acc_d;
          if (kl_q) begin
            c_out_flat   <= acc_d;
            c_valid_flat <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_os_flat.sv
module tb_systolic_array_os_flat;
  localparam int M = 8;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              step_valid = 1'b0;
  logic [M*32-1:0]   a_row_flat = '0;
  logic [N*32-1:0]   b_col_flat = '0;
  logic              k_first = 1'b0;
  logic              k_last = 1'b0;
  logic              step_ready;
  logic [M*N*32-1:0] c_out_flat;
  logic [M*N-1:0]    c_valid_flat;
  logic [M*N*32-1:0] psum_out_flat;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  systolic_array_os_flat #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid),
    .a_row_flat(a_row_flat), .b_col_flat(b_col_flat),
    .k_first(k_first), .k_last(k_last), .step_ready(step_ready),
    .c_out_flat(c_out_flat), .c_valid_flat(c_valid_flat),
    .psum_out_flat(psum_out_flat)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [M*32-1:0] splat_a(input logic [31:0] v);
    logic [M*32-1:0] r;
    for (int i = 0; i < M; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [N*32-1:0] splat_b(input logic [31:0] v);
    logic [N*32-1:0] r;
    for (int j = 0; j < N; j++) r[j*32 +: 32] = v;
    return r;
  endfunction

  // Exact FP32 encoding of a positive integer below 2^24.
  function automatic logic [31:0] int_to_f32(input int v);
    int          p;
    logic [31:0] m;
    logic [7:0]  e;
    if (v == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 24; k++) if (v >= (1 << k)) p = k;
    m = 32'(v) << (23 - p);
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  // Driver tasks: all start and end just after a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (!step_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!step_ready) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive_step(input logic [M*32-1:0] a, input logic [N*32-1:0] b,
                            input logic kf, input logic kl);
    wait_idle();
    a_row_flat = a;
    b_col_flat = b;
    k_first    = kf;
    k_last     = kl;
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
  endtask

  // Scoreboard pop: compare every published C word against the queue.
  task automatic publish_check(input string tag);
    logic [31:0] e;
    wait_idle();
    check({tag, "_cvalid"}, 64'(c_valid_flat), {64{1'b1}});
    for (int idx = 0; idx < M*N; idx++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check(tag, 64'(c_out_flat[idx*32 +: 32]), 64'(e));
      end
    end
  endtask

  logic [31:0] a_tbl [4] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000};
  logic [31:0] b_tbl [4] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40400000};
  logic [31:0] mm_row0 [4] = '{32'h41400000, 32'h41100000, 32'h41200000, 32'h41340000};

  function automatic logic [31:0] mm_exp(input int r, input int j);
    return mm_row0[(j - (r % 4) + 4) % 4];
  endfunction

  // Lane-wise special cases for a single multiply step with b = 2.0
  logic [31:0] sp_a   [8] = '{32'h7F800000, 32'h7F000000, 32'h00000001, 32'hFF800000,
                              32'h7FC00001, 32'h3F800000, 32'hBF800000, 32'h00800000};
  logic [31:0] sp_exp [8] = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'hFF800000,
                              32'h7FC00000, 32'h40000000, 32'hC0000000, 32'h01000000};
  // Lane-wise add cases: acc = ad_a1 + ad_a2 (b = 1.0 on both steps)
  logic [31:0] ad_a1  [8] = '{32'h7F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                              32'h3F800000, 32'h3F800001, 32'h7F7FFFFF, 32'h00800000};
  logic [31:0] ad_a2  [8] = '{32'hFF800000, 32'hBF800000, 32'h3F800000, 32'h33800000,
                              32'h33800001, 32'h33800000, 32'h7F7FFFFF, 32'h80C00000};
  logic [31:0] ad_exp [8] = '{32'h7FC00000, 32'h00000000, 32'h00000000, 32'h3F800000,
                              32'h3F800001, 32'h3F800002, 32'h7F800000, 32'h80000000};

  initial begin
    logic [M*32-1:0] av, av2;
    logic [N*32-1:0] bv;
    int ra [M][4];
    int rb [4][N];
    int kk, sum;

    // Reset and idle
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_ready_in_reset", 64'(step_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(step_ready), 64'd1);
    check("rst_psum_zero", 64'(|psum_out_flat), 64'd0);
    check("rst_cout_zero", 64'(|c_out_flat), 64'd0);
    check("rst_cvalid", 64'(c_valid_flat), 64'd0);

    // Single step 2.0 * 3.0, ready low for exactly two cycles
    for (int idx = 0; idx < M*N; idx++) exp_q.push_back(32'h40C00000);
    drive_step(splat_a(32'h40000000), splat_b(32'h40400000), 1'b1, 1'b1);
    check("single_ready_t1", 64'(step_ready), 64'd0);
    @(negedge clk);
    check("single_ready_t2", 64'(step_ready), 64'd0);
    @(negedge clk);
    check("single_ready_t3", 64'(step_ready), 64'd1);
    check("single_psum0", 64'(psum_out_flat[31:0]), 64'h40C00000);
    check("single_psum63", 64'(psum_out_flat[63*32 +: 32]), 64'h40C00000);
    publish_check("single_c");

    // 8x8x4 matmul, with busy-time requests carrying junk data
    for (int r = 0; r < M; r++)
      for (int j = 0; j < N; j++) exp_q.push_back(mm_exp(r, j));
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < M; i++) av[i*32 +: 32] = a_tbl[(k + i) % 4];
      for (int j = 0; j < N; j++) bv[j*32 +: 32] = b_tbl[(k + j) % 4];
      drive_step(av, bv, k == 0, k == 3);
      if (k == 0) check("mm_cvalid_cleared", 64'(c_valid_flat), 64'd0);
      if (k == 1 || k == 2) begin
        a_row_flat = splat_a(32'h42C80000);
        b_col_flat = splat_b(32'h42C80000);
        k_first    = 1'b1;
        k_last     = 1'b1;
        step_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        step_valid = 1'b0;
      end
    end
    publish_check("matmul_c");

    // New tile: k_first restarts, old C held until k_last
    drive_step(splat_a(32'h3F800000), splat_b(32'h3F800000), 1'b1, 1'b0);
    wait_idle();
    check("newtile_cvalid", 64'(c_valid_flat), 64'd0);
    for (int idx = 0; idx < M*N; idx += 9)
      check("newtile_psum", 64'(psum_out_flat[idx*32 +: 32]), 64'h3F800000);
    for (int idx = 0; idx < M*N; idx += 7)
      check("newtile_cout_held", 64'(c_out_flat[idx*32 +: 32]), 64'(mm_exp(idx / N, idx % N)));
    for (int idx = 0; idx < M*N; idx++) exp_q.push_back(32'h40000000);
    drive_step(splat_a(32'h3F800000), splat_b(32'h3F800000), 1'b0, 1'b1);
    publish_check("newtile_c");

    // Multiply corner cases
    for (int i = 0; i < M; i++) av[i*32 +: 32] = sp_a[i];
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(sp_exp[i]);
    drive_step(av, splat_b(32'h40000000), 1'b1, 1'b1);
    publish_check("mul_special");

    // Add corner cases: rounding, cancellation, overflow, underflow, Inf-Inf
    for (int i = 0; i < M; i++) begin
      av[i*32 +: 32]  = ad_a1[i];
      av2[i*32 +: 32] = ad_a2[i];
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(ad_exp[i]);
    drive_step(av, splat_b(32'h3F800000), 1'b1, 1'b0);
    drive_step(av2, splat_b(32'h3F800000), 1'b0, 1'b1);
    publish_check("add_special");

    // Random integer tiles, checked against an exact integer model
    for (int t = 0; t < 3; t++) begin
      kk = $urandom_range(1, 4);
      for (int k = 0; k < kk; k++) begin
        for (int i = 0; i < M; i++) ra[i][k] = $urandom_range(1, 8);
        for (int j = 0; j < N; j++) rb[k][j] = $urandom_range(1, 8);
      end
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++) begin
          sum = 0;
          for (int k = 0; k < kk; k++) sum += ra[i][k] * rb[k][j];
          exp_q.push_back(int_to_f32(sum));
        end
      for (int k = 0; k < kk; k++) begin
        for (int i = 0; i < M; i++) av[i*32 +: 32] = int_to_f32(ra[i][k]);
        for (int j = 0; j < N; j++) bv[j*32 +: 32] = int_to_f32(rb[k][j]);
        drive_step(av, bv, k == 0, k == kk - 1);
      end
      publish_check("rand_c");
    end

    // Reset during MUL aborts the step
    drive_step(splat_a(32'h40400000), splat_b(32'h40400000), 1'b1, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_ready", 64'(step_ready), 64'd1);
    check("midrst_psum_zero", 64'(|psum_out_flat), 64'd0);
    check("midrst_cvalid", 64'(c_valid_flat), 64'd0);
    repeat (2) @(negedge clk);
    check("midrst_psum_stays_zero", 64'(|psum_out_flat), 64'd0);

    // k_last-only step after reset accumulates onto zero
    for (int idx = 0; idx < M*N; idx++) exp_q.push_back(32'h40C00000);
    drive_step(splat_a(32'h40000000), splat_b(32'h40400000), 1'b0, 1'b1);
    publish_check("noinit_c");

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
